// File: rtl/sync_fifo_pkg.sv
// Shared default sizing for the CREM datapath FIFO and its storage array.
package sync_fifo_pkg;

    // Default word width carried through the FIFO
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Default number of entries (power of two)
    localparam int DEFAULT_MEM_DEPTH  = 8;

    // Pointer width: log2(depth) address bits plus one wrap bit
    localparam int DEFAULT_PTR_WIDTH  = 4;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// Register-file storage for sync_fifo: one synchronous write port and one
// asynchronous read port, so the head word is visible without read latency.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_PTR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    // Next-state of the array: only the addressed entry changes on a write
    always_comb begin
        mem_d = mem_q;
        if (wen) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage update; reset wipes every entry so stale reads return zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port is purely combinational from the registered array
    assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Pointers carry an extra wrap bit
// so full and empty are told apart without an occupancy counter.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
    parameter int PTR_WIDTH  = DEFAULT_PTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_inc,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  r_inc,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int ADDR_WIDTH = PTR_WIDTH - 1;

    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [PTR_WIDTH-1:0]  wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_d;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // Flags come straight from the registered pointers; requests are gated so
    // overflowing writes and underflowing reads leave all state untouched
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_WIDTH-1] != rd_ptr_q[PTR_WIDTH-1]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        wr_en    = w_inc && !full;
        rd_en    = r_inc && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
    end

    // Pointer registers, cleared immediately by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .wen   (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, fill, overflow, drain/underflow,
// simultaneous access across the pointer wrap, and mid-run reset.
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic       w_inc;
    logic [7:0] wr_data;
    logic       r_inc;
    logic       full;
    logic       empty;
    logic [7:0] rd_data;

    logic       clk_run;
    int         checks;
    int         errors;

    logic [7:0] fill_words [8] = '{8'hF1, 8'hF9, 8'hF5, 8'hF3, 8'hD1, 8'hE1, 8'h71, 8'hD5};
    logic [7:0] ovf_words  [7] = '{8'h31, 8'h3D, 8'h3D, 8'h3D, 8'h3D, 8'h3D, 8'h3D};
    logic [7:0] c_words    [5] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    logic [7:0] a_words    [3] = '{8'hA0, 8'hA1, 8'hA2};
    logic [7:0] b_words    [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic [7:0] sim_expect [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
    logic [7:0] tail_words [3] = '{8'hB1, 8'hB2, 8'hB3};

    sync_fifo #(
        .DATA_WIDTH (8),
        .MEM_DEPTH  (8),
        .PTR_WIDTH  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .w_inc   (w_inc),
        .wr_data (wr_data),
        .r_inc   (r_inc),
        .full    (full),
        .empty   (empty),
        .rd_data (rd_data)
    );

    // Clock held still until the initial reset check is done
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk     = 1'b0;
        clk_run = 1'b0;
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        w_inc   = 1'b0;
        r_inc   = 1'b0;
        wr_data = 8'h00;

        // 1. Reset with no clock activity
        #2;
        chk("reset_empty", 32'(empty), 32'(1));
        chk("reset_full", 32'(full), 32'(0));
        chk("reset_rd_data", 32'(rd_data), 32'h00);
        $display("reset: empty=%0d full=%0d rd_data=%02h", empty, full, rd_data);
        rst     = 1'b1;
        clk_run = 1'b1;
        tick();
        tick();
        chk("idle_empty", 32'(empty), 32'(1));
        chk("idle_full", 32'(full), 32'(0));
        chk("idle_rd_data", 32'(rd_data), 32'h00);

        // 2. Fill to full
        for (int i = 0; i < 8; i++) begin
            w_inc   = 1'b1;
            wr_data = fill_words[i];
            tick();
            w_inc   = 1'b0;
            chk("fill_empty", 32'(empty), 32'(0));
            chk("fill_full", 32'(full), 32'(i == 7));
            chk("fill_rd_data", 32'(rd_data), 32'hF1);
            $display("write %02h: empty=%0d full=%0d rd_data=%02h", fill_words[i], empty, full, rd_data);
        end

        // 3. Overflow attempts are dropped
        for (int i = 0; i < 7; i++) begin
            w_inc   = 1'b1;
            wr_data = ovf_words[i];
            tick();
            w_inc   = 1'b0;
            chk("ovf_full", 32'(full), 32'(1));
            chk("ovf_rd_data", 32'(rd_data), 32'hF1);
            $display("overflow write %02h: full=%0d rd_data=%02h", ovf_words[i], full, rd_data);
        end

        // 4. Drain eight words, then two underflow reads
        for (int i = 0; i < 10; i++) begin
            chk("drain_rd_data", 32'(rd_data), 32'((i < 8) ? fill_words[i] : 8'hF1));
            $display("read %0d: rd_data=%02h", i + 1, rd_data);
            r_inc = 1'b1;
            tick();
            r_inc = 1'b0;
            chk("drain_full", 32'(full), 32'(0));
            chk("drain_empty", 32'(empty), 32'(i >= 7));
        end
        chk("underflow_stale", 32'(rd_data), 32'hF1);

        // Advance both pointers to address 5 so the next fill wraps
        for (int i = 0; i < 5; i++) begin
            w_inc   = 1'b1;
            wr_data = c_words[i];
            tick();
        end
        w_inc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("adv_rd_data", 32'(rd_data), 32'(c_words[i]));
            $display("read: rd_data=%02h", rd_data);
            r_inc = 1'b1;
            tick();
        end
        r_inc = 1'b0;
        chk("adv_empty", 32'(empty), 32'(1));

        // 5. Three queued words, then simultaneous read/write across the wrap
        for (int i = 0; i < 3; i++) begin
            w_inc   = 1'b1;
            wr_data = a_words[i];
            tick();
        end
        w_inc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sim_rd_data", 32'(rd_data), 32'(sim_expect[i]));
            $display("simultaneous: wrote %02h read %02h", b_words[i], rd_data);
            w_inc   = 1'b1;
            r_inc   = 1'b1;
            wr_data = b_words[i];
            tick();
            w_inc   = 1'b0;
            r_inc   = 1'b0;
            chk("sim_empty", 32'(empty), 32'(0));
            chk("sim_full", 32'(full), 32'(0));
        end
        for (int i = 0; i < 3; i++) begin
            chk("tail_rd_data", 32'(rd_data), 32'(tail_words[i]));
            $display("read: rd_data=%02h", rd_data);
            r_inc = 1'b1;
            tick();
            r_inc = 1'b0;
        end
        chk("tail_empty", 32'(empty), 32'(1));

        // 6. Asynchronous reset while half full
        for (int i = 0; i < 4; i++) begin
            w_inc   = 1'b1;
            wr_data = fill_words[i];
            tick();
        end
        w_inc = 1'b0;
        chk("half_empty", 32'(empty), 32'(0));
        #1;
        rst = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 32'(1));
        chk("arst_full", 32'(full), 32'(0));
        chk("arst_rd_data", 32'(rd_data), 32'h00);
        $display("async reset: empty=%0d full=%0d rd_data=%02h", empty, full, rd_data);
        #1;
        rst = 1'b1;
        w_inc   = 1'b1;
        wr_data = 8'hAA;
        tick();
        w_inc = 1'b0;
        chk("post_rst_rd_data", 32'(rd_data), 32'hAA);
        chk("post_rst_empty", 32'(empty), 32'(0));
        $display("post-reset write AA: rd_data=%02h", rd_data);
        r_inc = 1'b1;
        tick();
        r_inc = 1'b0;
        chk("post_rst_drained", 32'(empty), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sync_fifo
